// File: rtl/multicycle_mem_responder.sv
// multicycle_mem_responder
// Word-addressed memory array with a fixed-latency read pipeline. One request
// per cycle, no backpressure; read data emerges LATENCY cycles after issue,
// qualified by data_valid. Bubbles travel down the pipe so request gaps are
// preserved at the output.

module multicycle_mem_responder #(
  parameter int unsigned DWIDTH     = 16,
  parameter int unsigned AWIDTH     = 16,
  parameter int unsigned WORDS_LOG2 = 15,
  parameter int unsigned LATENCY    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              wr,
  input  logic [AWIDTH-1:0] addr,
  input  logic [DWIDTH-1:0] data_in,
  output logic [DWIDTH-1:0] data_out,
  output logic              data_valid
);

  localparam int unsigned DEPTH = 32'(1) << WORDS_LOG2;

  // Storage is deliberately not reset; contents survive rst.
  logic [DWIDTH-1:0]     r_mem [DEPTH];

  // Pipeline stage 0 is the spec's stage 1; stage LATENCY-1 drives the outputs.
  logic [LATENCY-1:0]    r_vld;
  logic [DWIDTH-1:0]     r_dat [LATENCY];

  logic [WORDS_LOG2-1:0] w_idx;
  logic                  w_wr_req;
  logic                  w_rd_req;
  logic [AWIDTH-1:0]     w_unused_addr;

  // Byte address to word index; addr[0] and bits above the array are dropped.
  assign w_idx         = addr[WORDS_LOG2:1];
  assign w_unused_addr = addr;

  // Requests presented together with rst are discarded entirely.
  assign w_wr_req = enable & wr & ~rst;
  assign w_rd_req = enable & ~wr;

  // Array write port: new data is visible to a read sampled on the next edge.
  always_ff @(posedge clk) begin
    if (w_wr_req) begin
      r_mem[w_idx] <= data_in;
    end
  end

  // Read pipeline: sample array into stage 0, shift every stage each edge.
  // Bubble stages carry zero data so data_out is 0 whenever data_valid is 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld <= '0;
      for (int i = 0; i < int'(LATENCY); i++) begin
        r_dat[i] <= '0;
      end
    end else begin
      r_vld[0] <= w_rd_req;
      r_dat[0] <= w_rd_req ? r_mem[w_idx] : '0;
      for (int i = 1; i < int'(LATENCY); i++) begin
        r_vld[i] <= r_vld[i-1];
        r_dat[i] <= r_dat[i-1];
      end
    end
  end

  assign data_valid = r_vld[LATENCY-1];
  assign data_out   = r_dat[LATENCY-1];

endmodule

// File: tb/tb_multicycle_mem_responder.sv
// Bench for multicycle_mem_responder: three instances (LATENCY 4, 1, 8) share
// one request stream; a cycle-indexed schedule of expected outputs is built
// from a plain memory array and compared every cycle.

module tb_multicycle_mem_responder;

  localparam int unsigned NCYC = 2048;
  localparam int unsigned NDUT = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        wr;
  logic [15:0] addr;
  logic [15:0] data_in;
  logic [15:0] dout [NDUT];
  logic        dv   [NDUT];

  int          lat [NDUT] = '{4, 1, 8};

  // Reference state: memory contents and expected output per cycle per DUT.
  logic [15:0] mem_m [32768];
  bit          ev    [NDUT][NCYC];
  logic [15:0] ed    [NDUT][NCYC];

  int cyc;
  int n_checks;
  int n_errors;

  always #5 clk = ~clk;

  multicycle_mem_responder #(.LATENCY(4)) u_l4 (
    .clk(clk), .rst(rst), .enable(enable), .wr(wr), .addr(addr),
    .data_in(data_in), .data_out(dout[0]), .data_valid(dv[0])
  );

  multicycle_mem_responder #(.LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst), .enable(enable), .wr(wr), .addr(addr),
    .data_in(data_in), .data_out(dout[1]), .data_valid(dv[1])
  );

  multicycle_mem_responder #(.LATENCY(8)) u_l8 (
    .clk(clk), .rst(rst), .enable(enable), .wr(wr), .addr(addr),
    .data_in(data_in), .data_out(dout[2]), .data_valid(dv[2])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  // One bus cycle: drive, compare outputs mid-cycle, advance model, cross edge.
  task automatic step(input bit r, input bit en, input bit w,
                      input logic [15:0] a, input logic [15:0] d);
    logic [14:0] idx;
    rst     = r;
    enable  = en;
    wr      = w;
    addr    = a;
    data_in = d;
    @(negedge clk);
    for (int k = 0; k < int'(NDUT); k++) begin
      check($sformatf("valid_L%0d", lat[k]), 32'(dv[k]), 32'(ev[k][cyc]));
      check($sformatf("data_L%0d", lat[k]), 32'(dout[k]),
            ev[k][cyc] ? 32'(ed[k][cyc]) : 32'h0);
    end
    idx = a[15:1];
    if (r) begin
      for (int k = 0; k < int'(NDUT); k++)
        for (int j = cyc + 1; j < int'(NCYC); j++) ev[k][j] = 1'b0;
    end else if (en && w) begin
      mem_m[idx] = d;
    end else if (en) begin
      for (int k = 0; k < int'(NDUT); k++) begin
        if (cyc + lat[k] < int'(NCYC)) begin
          ev[k][cyc + lat[k]] = 1'b1;
          ed[k][cyc + lat[k]] = mem_m[idx];
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
  endtask

  task automatic wr_word(input logic [15:0] a, input logic [15:0] d);
    step(1'b0, 1'b1, 1'b1, a, d);
  endtask

  task automatic rd_word(input logic [15:0] a);
    step(1'b0, 1'b1, 1'b0, a, 16'h0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    cyc      = 0;
    rst      = 1'b1;
    enable   = 1'b0;
    wr       = 1'b0;
    addr     = 16'h0;
    data_in  = 16'h0;
    repeat (3) @(posedge clk);
    #1;

    // Post-reset outputs must be idle
    idle(2);

    // Preload words 0..63 so every later read has a defined value
    for (int i = 0; i < 64; i++) wr_word(16'(i * 2), 16'($urandom));

    // Basic write then read
    wr_word(16'h0010, 16'hBEEF);
    rd_word(16'h0010);
    idle(9);

    // Odd byte address aliases onto the same word
    wr_word(16'h0021, 16'h1234);
    rd_word(16'h0020);
    idle(9);

    // Back-to-back reads with a bubble
    for (int i = 0; i < 4; i++) wr_word(16'(i * 2), 16'hA000 + 16'(i));
    rd_word(16'h0000);
    rd_word(16'h0004);
    idle(1);
    rd_word(16'h0002);
    rd_word(16'h0006);
    idle(9);

    // Write behind an in-flight read to the same word
    wr_word(16'h000A, 16'h1111);
    rd_word(16'h000A);
    wr_word(16'h000A, 16'h2222);
    rd_word(16'h000A);
    idle(9);

    // Reset mid-flight, with a write presented alongside rst
    rd_word(16'h0010);
    rd_word(16'h0012);
    rd_word(16'h0014);
    step(1'b1, 1'b1, 1'b1, 16'h0010, 16'hDEAD);
    idle(3);
    rd_word(16'h0010);
    rd_word(16'h000A);
    idle(9);

    // Randomized traffic including occasional resets
    for (int i = 0; i < 600; i++) begin
      bit          r_b;
      bit          en_b;
      bit          w_b;
      logic [15:0] a_v;
      r_b  = ($urandom_range(99) < 2);
      en_b = ($urandom_range(99) < 70);
      w_b  = ($urandom_range(99) < 40);
      a_v  = 16'({$urandom_range(63), 1'($urandom)});
      step(r_b, en_b, w_b, a_v, 16'($urandom));
    end
    idle(10);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/multicycle_mem_responder.md
# multicycle_mem_responder

Pipelined multi-cycle memory responder serving the processor's instruction or data memory port. It accepts one word-aligned read or write request per cycle and returns read data a fixed `LATENCY` cycles later, qualified by a `data_valid` pulse. It replaces the single-cycle memory models so that cache-fill and stall logic can be developed against realistic memory latency.

## Interface
- `DWIDTH`, default 16: data word width in bits.
- `AWIDTH`, default 16: byte-address width in bits.
- `WORDS_LOG2`, default 15: log2 of the array depth in words. Must be ≤ `AWIDTH`-1.
- `LATENCY`, default 4: read latency in cycles. Legal range is 1..8.

Ports:
- `clk`  in  1  clock. All state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `enable`  in  1  request valid this cycle.
- `wr`  in  1  1 = write, 0 = read. Ignored when `enable`=0.
- `addr`  in  AWIDTH  byte address. Word index is `addr[WORDS_LOG2:1]`; `addr[0]` and bits above `WORDS_LOG2` are ignored.
- `data_in`  in  DWIDTH  write data.
- `data_out`  out  DWIDTH  read data. Equals 0 whenever `data_valid`=0.
- `data_valid`  out  1  one-cycle pulse per completed read.

## Operation
- The storage array holds 2^`WORDS_LOG2` words of `DWIDTH` bits. Reset does not clear the array contents; initial contents are X unless preloaded by the bench.
- No backpressure: a request is accepted in every cycle where `enable`=1, and back-to-back requests are legal.
- **Write** (`enable`=1, `wr`=1):
  - `data_in` is stored at the word index on the same rising edge.
  - No `data_valid` pulse is produced.
- **Read** (`enable`=1, `wr`=0):
  - The array is sampled at the accepting edge into stage 1 of a `LATENCY`-deep pipeline. Each stage holds a valid bit and a data word.
  - Each edge shifts every stage forward by one.
  - `data_valid`/`data_out` are driven from stage `LATENCY`.
- **Ordering:**
  - Reads complete strictly in issue order.
  - A read issued the cycle after a write to the same word returns the new data.
  - A write issued while an earlier read to the same word is still in flight does not change that read's result; it returns the old value.
- **Idle cycles** (`enable`=0) insert a bubble with valid=0. Bubbles propagate, so gaps between requests are preserved exactly at the output.
- **Reset:**
  - All pipeline valid bits clear and stage data clears to 0.
  - Reads in flight at reset are dropped and never produce `data_valid`.
  - A request presented in the same cycle as `rst`=1 is ignored, including writes: the array is not modified.

## Timing
- Cycle numbering: a request presented in cycle 0 is sampled at the edge that ends cycle 0.
- A read presented in cycle n has `data_valid`=1 and `data_out`=word exactly in cycle n+`LATENCY`. For `LATENCY`=4 this is cycle n+4.
- Throughput is one read per cycle. N consecutive reads give N consecutive `data_valid` cycles.
- A write takes effect at the end of its cycle and is visible to a read presented in the next cycle.
- After reset deasserts: `data_valid`=0 and `data_out`=0 until the first read completes, which is no earlier than `LATENCY` cycles after it is issued.
- `data_out` and `data_valid` are registered outputs with no combinational path from the inputs.

## Test plan
- **Basic write/read:** write 0xBEEF to addr 0x0010, then read 0x0010 in the next cycle (`LATENCY`=4) -> `data_valid`=1 with `data_out`=0xBEEF exactly 4 cycles after the read; `data_out`=0 in all other cycles.
- **Word alignment:** write 0x1234 to addr 0x0021, then read 0x0020 -> returns 0x1234.
- **Back-to-back and bubbles:** preload words 0..3 with 0xA000..0xA003. Read 0,2,idle,1,3 on consecutive cycles -> outputs are 0xA000, 0xA002, bubble, 0xA001, 0xA003 in cycles 4,5,6,7,8, with `data_valid` 1,1,0,1,1.
- **In-flight write hazard:** word 5=0x1111. Read 5 in cycle 0, write 0x2222 to 5 in cycle 1, read 5 in cycle 2 -> cycle 4 returns 0x1111 and cycle 6 returns 0x2222.
- **Reset mid-operation:**
  - Issue reads in cycles 0–2, then assert `rst` in cycle 3 -> no `data_valid` pulse in cycles 4–6.
  - A write presented together with `rst` leaves the array unchanged.
  - Array contents written before the reset survive it.
- **Latency parameter:** repeat the basic test with `LATENCY`=1 and `LATENCY`=8 -> valid in cycle n+1 and n+8 respectively.
